// File: rtl/cordic_angle_reduce.sv
// cordic_angle_reduce
//   Angle pre-reduction ahead of the iterative CORDIC cosine unit. It takes an
//   IEEE-754 single-precision angle in radians and returns a non-negative
//   Q1.20 angle in [0, pi/2]. It also returns a negate flag, so that
//   cos(dataa) = (negate ? -1 : 1) * cos(angle_out).
//
//   Ports
//     clk        rising-edge system clock
//     reset      asynchronous, active-high reset
//     clk_en     start strobe, sampled only while idle
//     dataa      IEEE-754 single angle in radians
//     angle_out  reduced angle, Q1.20 two's complement, in [0, HALF_PI_Q]
//     negate     downstream cosine result must be sign-inverted
//     err        input was NaN, Inf or |x| >= 128
//     done       one-cycle pulse; outputs are valid from here to the next start
//
//   Schedule: IDLE -> ALIGN -> REDUCE (x5) -> FOLD_PI -> FOLD_HALF -> IDLE.
//   done rises 8 clocks after the accepted strobe.
module cordic_angle_reduce #(
  parameter int          FRAC_BITS = 20,
  parameter logic [27:0] PI_Q      = 28'd3294199,
  parameter logic [27:0] HALF_PI_Q = 28'd1647099,
  parameter logic [27:0] TWO_PI_Q  = 28'd6588397
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic [31:0] dataa,
  output logic [21:0] angle_out,
  output logic        negate,
  output logic        err,
  output logic        done
);

  // Biased exponent at which the 24-bit mantissa is already in Q8.FRAC_BITS
  // (127 bias + 23 fraction bits - FRAC_BITS). Four exponents above it reach
  // |x| >= 128, which no longer fits the 8 integer bits of r.
  localparam logic [7:0] ALIGN_E = 8'(150 - FRAC_BITS);
  localparam logic [7:0] ERR_E   = 8'(154 - FRAC_BITS);

  typedef enum logic [2:0] {IDLE, ALIGN, REDUCE, FOLD_PI, FOLD_HALF} state_t;

  state_t      state_q;
  logic [7:0]  exp_q;
  logic [23:0] man_q;
  logic [27:0] r_q;
  logic [2:0]  k_q;
  logic        err_work_q;
  logic [21:0] angle_q;
  logic        negate_q;
  logic        err_q;
  logic        done_q;

  // cos is even, so the sign bit is deliberately not used.
  logic sign_unused;
  assign sign_unused = dataa[31];

  logic [27:0] r_align_d;
  logic        range_err_d;
  logic [7:0]  lsh_amt;
  logic [7:0]  rsh_dist;
  logic [7:0]  rsh_amt;
  logic [27:0] sub_val;
  logic [27:0] r_reduce_d;
  logic [27:0] r_fold_d;
  logic [21:0] angle_d;
  logic        negate_d;

  always_comb begin
    range_err_d = (exp_q == 8'd255) || (exp_q >= ERR_E);
    lsh_amt     = exp_q - ALIGN_E;
    rsh_dist    = ALIGN_E - exp_q;
    // Right shifts beyond 31 only ever produce zero; clamp to keep the
    // shifter small.
    rsh_amt     = (rsh_dist > 8'd31) ? 8'd31 : rsh_dist;
    r_align_d   = '0;
    if (!range_err_d) begin
      if (exp_q >= ALIGN_E) r_align_d = {4'b0, man_q} << lsh_amt;
      else                  r_align_d = {4'b0, man_q} >> rsh_amt;
    end
  end

  // Binary restoring reduction: subtracting 2pi*16, *8, ... *1 in turn leaves
  // r mod 2pi, because r < 128 < 32*2pi.
  always_comb begin
    sub_val    = TWO_PI_Q << k_q;
    r_reduce_d = (r_q >= sub_val) ? (r_q - sub_val) : r_q;
  end

  // Reflect (pi, 2pi) onto (0, pi): cos(2pi - x) = cos(x).
  always_comb begin
    r_fold_d = (r_q > PI_Q) ? (TWO_PI_Q - r_q) : r_q;
  end

  // Reflect (pi/2, pi] onto [0, pi/2): cos(pi - x) = -cos(x).
  always_comb begin
    angle_d  = 22'(r_q);
    negate_d = 1'b0;
    if (r_q > HALF_PI_Q) begin
      angle_d  = 22'(PI_Q - r_q);
      negate_d = 1'b1;
    end
  end

  // Working datapath; every value is loaded before the FSM consumes it, so
  // none of it needs a reset.
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: begin
        if (clk_en) begin
          exp_q <= dataa[30:23];
          // Hidden bit follows the exponent, so denormals flush to zero.
          man_q <= {|dataa[30:23], dataa[22:0]};
        end
      end
      ALIGN: begin
        r_q        <= r_align_d;
        err_work_q <= range_err_d;
        k_q        <= 3'd4;
      end
      REDUCE: begin
        r_q <= r_reduce_d;
        k_q <= k_q - 3'd1;
      end
      FOLD_PI: r_q <= r_fold_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      angle_q  <= '0;
      negate_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE:    if (clk_en) state_q <= ALIGN;
        ALIGN:   state_q <= REDUCE;
        REDUCE:  if (k_q == 3'd0) state_q <= FOLD_PI;
        FOLD_PI: state_q <= FOLD_HALF;
        FOLD_HALF: begin
          angle_q  <= angle_d;
          negate_q <= negate_d;
          err_q    <= err_work_q;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign angle_out = angle_q;
  assign negate    = negate_q;
  assign err       = err_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cordic_angle_reduce.sv
// Bench for cordic_angle_reduce: a fixed vector table, random angles checked
// against an arithmetic (modulo-based) reference, an ignored-strobe sequence,
// and a mid-operation asynchronous reset.
module tb_cordic_angle_reduce;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic [31:0] dataa;
  logic [21:0] angle_out;
  logic        negate;
  logic        err;
  logic        done;

  cordic_angle_reduce dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .dataa     (dataa),
    .angle_out (angle_out),
    .negate    (negate),
    .err       (err),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [21:0] ang;
    logic        neg;
    logic        er;
    int          cyc_due;
  } exp_t;

  typedef struct {
    logic [31:0] x;
    logic [21:0] ang;
    logic        neg;
    logic        er;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic done_prev = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: r mod 2pi by the % operator, then the two cosine symmetries.
  function automatic exp_t model(input logic [31:0] x);
    exp_t   o;
    int     ei;
    longint m;
    longint r;
    ei = int'(x[30:23]);
    m  = (ei == 0) ? 64'd0 : (64'h800000 | longint'(x[22:0]));
    o.neg = 1'b0;
    o.er  = 1'b0;
    o.cyc_due = 0;
    if (ei == 255 || ei >= 134) begin
      o.er = 1'b1;
      r = 0;
    end else if (ei >= 130) begin
      r = m << (ei - 130);
    end else begin
      r = m >> (130 - ei);
    end
    r = r % 6588397;
    if (r > 3294199) r = 6588397 - r;
    if (r > 1647099) begin
      o.ang = 22'(3294199 - r);
      o.neg = 1'b1;
    end else begin
      o.ang = 22'(r);
    end
    return o;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation,
  // including the cycle it was due.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, want no pulse", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("angle_out", longint'(angle_out), longint'(e.ang));
          chk("negate", longint'(negate), longint'(e.neg));
          chk("err", longint'(err), longint'(e.er));
          chk("done_cycle", longint'(cyc), longint'(e.cyc_due));
        end
      end
      if (done && done_prev) begin
        total++;
        bad++;
        $display("FAIL done_width: got done high 2 cycles, want 1 (cycle %0d)", cyc);
      end
      done_prev = done;
    end
  end

  task automatic start(input logic [31:0] x, input exp_t e);
    @(negedge clk);
    clk_en = 1'b1;
    dataa  = x;
    e.cyc_due = cyc + 9;
    sb.push_back(e);
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got %0d pending results, want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic start_vec(input vec_t v);
    exp_t e;
    e.ang = v.ang;
    e.neg = v.neg;
    e.er  = v.er;
    e.cyc_due = 0;
    start(v.x, e);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want finish");
    $fatal(1);
  end

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{32'h00000000, 22'd0,       1'b0, 1'b0};
    vecs[1]  = '{32'h3F800000, 22'd1048576, 1'b0, 1'b0};  //  1.0
    vecs[2]  = '{32'hBF800000, 22'd1048576, 1'b0, 1'b0};  // -1.0
    vecs[3]  = '{32'h40400000, 22'd148471,  1'b1, 1'b0};  //  3.0
    vecs[4]  = '{32'hC0E00000, 22'd751635,  1'b0, 1'b0};  // -7.0
    vecs[5]  = '{32'h43480000, 22'd0,       1'b0, 1'b1};  //  200.0
    vecs[6]  = '{32'h7F800000, 22'd0,       1'b0, 1'b1};  // +Inf
    vecs[7]  = '{32'h7FC00000, 22'd0,       1'b0, 1'b1};  //  NaN
    vecs[8]  = '{32'h3F800000, 22'd1048576, 1'b0, 1'b0};  // err clears
    vecs[9]  = '{32'h40490FDC, 22'd0,       1'b1, 1'b0};  // r == PI_Q
    vecs[10] = '{32'h3FC90FD8, 22'd1647099, 1'b0, 1'b0};  // r == HALF_PI_Q
    vecs[11] = '{32'h40490FE0, 22'd2,       1'b1, 1'b0};  // r == PI_Q + 1
    vecs[12] = '{32'h42FFFFFF, 22'd844419,  1'b1, 1'b0};  // largest legal
    vecs[13] = '{32'h43000000, 22'd0,       1'b0, 1'b1};  // 128.0 exactly
    vecs[14] = '{32'h00000001, 22'd0,       1'b0, 1'b0};  // denormal

    reset  = 1'b1;
    clk_en = 1'b0;
    dataa  = '0;
    repeat (2) @(negedge clk);
    chk("rst_angle_out", longint'(angle_out), 0);
    chk("rst_negate", longint'(negate), 0);
    chk("rst_err", longint'(err), 0);
    chk("rst_done", longint'(done), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 15; i++) start_vec(vecs[i]);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] x;
      int sel;
      logic [7:0] ex;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      ex = 8'd0;
      else if (sel == 1) ex = 8'd255;
      else               ex = 8'($urandom_range(110, 135));
      x = {1'($urandom_range(0, 1)), ex, 23'($urandom)};
      start(x, model(x));
      drain();
    end

    // Strobes while busy must be ignored; a strobe coincident with the fall
    // of done must be accepted.
    @(negedge clk);
    for (int i = 0; i <= 9; i++) begin
      clk_en = (i == 0 || i == 2 || i == 5 || i == 9);
      dataa  = (i == 0) ? 32'h40400000 : ((i == 9) ? 32'hC0E00000 : 32'h3F800000);
      if (i == 0 || i == 9) begin
        exp_t e;
        e = model(dataa);
        e.cyc_due = cyc + 9;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    clk_en = 1'b0;
    drain();

    // Outputs hold between operations; reset mid-operation clears them at
    // once and suppresses done.
    chk("hold_angle_out", longint'(angle_out), 751635);
    clk_en = 1'b1;
    dataa  = 32'h40400000;
    @(negedge clk);
    clk_en = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_angle_out", longint'(angle_out), 0);
    chk("arst_negate", longint'(negate), 0);
    chk("arst_err", longint'(err), 0);
    chk("arst_done", longint'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    start(32'h3F800000, model(32'h3F800000));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
